master_port_rw: RTL

//  Parametrised read/write bus master port, successor to the write-only serial master port.
//  - Accepts one request at a time from the local master (address, write data, mode).
//  - Arbitrates for the serial system bus and shifts the address out MSB first.
//  - Write: shifts the data out MSB first. Read: shifts the data in MSB first.
//  - Returns a one-cycle response with read data and an error flag (stall timeout).

---
 rtl/master_port_rw_if.sv | 34 +++
 rtl/master_port_rw.sv | 96 +++++++++
 2 files changed

// File: rtl/master_port_rw_if.sv
// Local request/response and serial system-bus signals of the read/write master port.
// The master modport is the port's own view; slave is the view of whoever drives it.
interface master_port_rw_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rsp_valid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;
  logic              mp_breq;
  logic              mp_bgnt;
  logic              mp_mode;
  logic              mp_addr;
  logic              mp_wdata;
  logic              mp_valid;
  logic              mp_ready;
  logic              mp_rdata;
  logic              mp_rvalid;

  modport master (
    input  m_valid, m_write, m_addr, m_wdata, mp_bgnt, mp_ready, mp_rdata, mp_rvalid,
    output m_ready, m_rsp_valid, m_rdata, m_err, mp_breq, mp_mode, mp_addr, mp_wdata, mp_valid
  );

  modport slave (
    output m_valid, m_write, m_addr, m_wdata, mp_bgnt, mp_ready, mp_rdata, mp_rvalid,
    input  m_ready, m_rsp_valid, m_rdata, m_err, mp_breq, mp_mode, mp_addr, mp_wdata, mp_valid
  );
endinterface

// File: rtl/master_port_rw.sv
// Read/write serial bus master port: takes one local request, wins the bus, shifts the
// address out, then shifts write data out or read data in, and returns a one-cycle response.
module master_port_rw #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  master_port_rw_if.master bus
);
  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int SW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
  localparam logic [SW-1:0] S_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RDATA, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] rdata_sh;
  logic [CW-1:0]     bit_cnt;
  logic [SW-1:0]     stall_cnt;
  logic              mode_q;
  logic              err_q;

  logic idle_rdy, accept, tx_phase, progress, stall, timeout_hit, own_bus;

  assign idle_rdy    = (state_q == IDLE) && !rst;
  assign accept      = idle_rdy && bus.m_valid;
  assign tx_phase    = (state_q == ADDR) || (state_q == WDATA);
  assign progress    = (tx_phase && bus.mp_ready) || ((state_q == RDATA) && bus.mp_rvalid);
  assign stall       = (tx_phase || (state_q == RDATA)) && !progress;
  // Progress and the final stall are mutually exclusive, so a stall alone decides the abort.
  assign timeout_hit = (TIMEOUT != 0) && stall && (stall_cnt == S_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (bus.mp_bgnt) state_d = ADDR;
      ADDR: begin
        if (progress && (bit_cnt == A_LAST)) state_d = mode_q ? WDATA : RDATA;
        else if (timeout_hit)                state_d = DONE;
      end
      WDATA, RDATA: if ((progress && (bit_cnt == D_LAST)) || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_sh   <= '0;
      data_sh   <= '0;
      rdata_sh  <= '0;
      bit_cnt   <= '0;
      stall_cnt <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_sh  <= bus.m_addr;
        data_sh  <= bus.m_wdata;
        mode_q   <= bus.m_write;
        rdata_sh <= '0;
        err_q    <= 1'b0;
      end
      if ((state_q == ADDR) && progress)  addr_sh  <= addr_sh << 1;
      if ((state_q == WDATA) && progress) data_sh  <= data_sh << 1;
      if ((state_q == RDATA) && progress) rdata_sh <= {rdata_sh[DATA_W-2:0], bus.mp_rdata};
      if (timeout_hit) err_q <= 1'b1;
      // Both counters restart on every state change so each phase counts from zero.
      if (state_d != state_q) bit_cnt <= '0;
      else if (progress)      bit_cnt <= bit_cnt + CW'(1);
      if ((state_d != state_q) || !stall) stall_cnt <= '0;
      else                                stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign own_bus         = (state_q == REQ) || (state_q == ADDR) || (state_q == WDATA) || (state_q == RDATA);
  assign bus.m_ready     = idle_rdy;
  assign bus.m_rsp_valid = (state_q == DONE);
  assign bus.m_err       = (state_q == DONE) && err_q;
  assign bus.m_rdata     = ((state_q == DONE) && !mode_q && !err_q) ? rdata_sh : '0;
  assign bus.mp_breq     = own_bus;
  assign bus.mp_mode     = own_bus && mode_q;
  assign bus.mp_valid    = tx_phase;
  assign bus.mp_addr     = (state_q == ADDR) && addr_sh[ADDR_W-1];
  assign bus.mp_wdata    = (state_q == WDATA) && data_sh[DATA_W-1];
endmodule
